// File: rtl/branch_ctrl_if.sv
// Bundle of the EX-stage branch, comparator, fetch-prediction, redirect
// and statistics signals of the branch controller.
interface branch_ctrl_if;
  logic        stall_i;
  logic        ex_valid_i;
  logic        ex_is_branch_i;
  logic [2:0]  ex_funct3_i;
  logic [31:0] ex_pc_i;
  logic [31:0] ex_target_i;
  logic        ex_pred_taken_i;
  logic        BrUn_o;
  logic        BrEq_i;
  logic        BrLt_i;
  logic [31:0] if_pc_i;
  logic        if_pred_taken_o;
  logic        PCSel_o;
  logic [31:0] redirect_pc_o;
  logic        flush_o;
  logic        illegal_br_o;
  logic [31:0] stat_branches_o;
  logic [31:0] stat_mispred_o;

  // Pipeline side: drives EX/IF state and comparator results.
  modport master (
    output stall_i, ex_valid_i, ex_is_branch_i, ex_funct3_i, ex_pc_i,
           ex_target_i, ex_pred_taken_i, BrEq_i, BrLt_i, if_pc_i,
    input  BrUn_o, if_pred_taken_o, PCSel_o, redirect_pc_o, flush_o,
           illegal_br_o, stat_branches_o, stat_mispred_o
  );

  // Branch controller side.
  modport slave (
    input  stall_i, ex_valid_i, ex_is_branch_i, ex_funct3_i, ex_pc_i,
           ex_target_i, ex_pred_taken_i, BrEq_i, BrLt_i, if_pc_i,
    output BrUn_o, if_pred_taken_o, PCSel_o, redirect_pc_o, flush_o,
           illegal_br_o, stat_branches_o, stat_mispred_o
  );
endinterface

// File: rtl/branch_ctrl.sv
// EX-stage branch resolution: outcome from comparator flags, mispredict
// detection with a one-cycle registered redirect/flush, and a table of
// 2-bit saturating counters providing fetch-time predictions.
module branch_ctrl #(
  parameter int         IDX_W    = 4,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input logic         clk_i,
  input logic         rst_ni,
  branch_ctrl_if.slave bif
);
  localparam int N_ENT = 2 ** IDX_W;

  logic [1:0]       bht_q [N_ENT];
  logic             pcsel_q, pcsel_d;
  logic [31:0]      redirect_q, redirect_d;
  logic             illegal_q, illegal_d;
  logic [31:0]      stat_br_q, stat_br_d;
  logic [31:0]      stat_mp_q, stat_mp_d;
  logic [1:0]       cnt_d;

  logic             res_s;
  logic             legal_s;
  logic             taken_s;
  logic             update_s;
  logic             mispred_s;
  logic [IDX_W-1:0] ex_idx_s;
  logic [IDX_W-1:0] if_idx_s;
  logic [1:0]       cnt_cur_s;

  logic unused_pc_bits_s;
  assign unused_pc_bits_s = ^{bif.ex_pc_i[31:IDX_W+2], bif.ex_pc_i[1:0],
                              bif.if_pc_i[31:IDX_W+2], bif.if_pc_i[1:0]};

  assign bif.BrUn_o = bif.ex_funct3_i[1];
  assign ex_idx_s   = bif.ex_pc_i[IDX_W+1:2];
  assign if_idx_s   = bif.if_pc_i[IDX_W+1:2];
  assign cnt_cur_s  = bht_q[ex_idx_s];

  // Wrong-path instructions sit in EX while the flush pulse is high.
  assign res_s = bif.ex_valid_i & bif.ex_is_branch_i & ~bif.stall_i & ~pcsel_q;

  // Decode funct3 into legality and the actual branch outcome.
  always_comb begin
    legal_s = 1'b1;
    taken_s = 1'b0;
    case (bif.ex_funct3_i)
      3'b000:          taken_s = bif.BrEq_i;
      3'b001:          taken_s = ~bif.BrEq_i;
      3'b100, 3'b110:  taken_s = bif.BrLt_i;
      3'b101, 3'b111:  taken_s = ~bif.BrLt_i;
      default: begin
        legal_s = 1'b0;
        taken_s = 1'b0;
      end
    endcase
  end

  assign update_s  = res_s & legal_s;
  assign mispred_s = update_s & (taken_s != bif.ex_pred_taken_i);

  // Next-state for redirect, illegal pulse and statistics.
  always_comb begin
    pcsel_d    = mispred_s;
    illegal_d  = res_s & ~legal_s;
    redirect_d = redirect_q;
    stat_br_d  = stat_br_q;
    stat_mp_d  = stat_mp_q;
    if (mispred_s) begin
      redirect_d = taken_s ? bif.ex_target_i : (bif.ex_pc_i + 32'd4);
    end else begin
      redirect_d = redirect_q;
    end
    if (update_s) begin
      stat_br_d = stat_br_q + 32'd1;
    end else begin
      stat_br_d = stat_br_q;
    end
    if (mispred_s) begin
      stat_mp_d = stat_mp_q + 32'd1;
    end else begin
      stat_mp_d = stat_mp_q;
    end
  end

  // Saturating counter step for the resolving branch's entry.
  always_comb begin
    cnt_d = cnt_cur_s;
    if (taken_s) begin
      cnt_d = (cnt_cur_s == 2'b11) ? 2'b11 : (cnt_cur_s + 2'b01);
    end else begin
      cnt_d = (cnt_cur_s == 2'b00) ? 2'b00 : (cnt_cur_s - 2'b01);
    end
  end

  // Control/statistics registers; reset drops any pending redirect.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pcsel_q    <= 1'b0;
      redirect_q <= 32'd0;
      illegal_q  <= 1'b0;
      stat_br_q  <= 32'd0;
      stat_mp_q  <= 32'd0;
    end else begin
      pcsel_q    <= pcsel_d;
      redirect_q <= redirect_d;
      illegal_q  <= illegal_d;
      stat_br_q  <= stat_br_d;
      stat_mp_q  <= stat_mp_d;
    end
  end

  // Branch history table; read port below sees pre-update contents.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_ENT; i++) begin
        bht_q[i] <= CNT_INIT;
      end
    end else if (update_s) begin
      bht_q[ex_idx_s] <= cnt_d;
    end
  end

  assign bif.if_pred_taken_o = bht_q[if_idx_s][1];
  assign bif.PCSel_o         = pcsel_q;
  assign bif.flush_o         = pcsel_q;
  assign bif.redirect_pc_o   = redirect_q;
  assign bif.illegal_br_o    = illegal_q;
  assign bif.stat_branches_o = stat_br_q;
  assign bif.stat_mispred_o  = stat_mp_q;
endmodule

// File: tb/tb_branch_ctrl.sv
// Directed-vector bench for branch_ctrl with hand-computed expectations.
module tb_branch_ctrl;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   exp_br;
  int   exp_mp;

  branch_ctrl_if bif ();

  branch_ctrl #(.IDX_W(4), .CNT_INIT(2'b01)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bif    (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bif.ex_valid_i      = 1'b0;
    bif.ex_is_branch_i  = 1'b0;
    bif.ex_pred_taken_i = 1'b0;
    bif.stall_i         = 1'b0;
  endtask

  task automatic drive(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] tgt,
                       input logic pred, input logic eq, input logic lt);
    bif.ex_valid_i      = 1'b1;
    bif.ex_is_branch_i  = 1'b1;
    bif.ex_funct3_i     = f3;
    bif.ex_pc_i         = pc;
    bif.ex_target_i     = tgt;
    bif.ex_pred_taken_i = pred;
    bif.BrEq_i          = eq;
    bif.BrLt_i          = lt;
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_br"}, bif.stat_branches_o, exp_br);
    check({tag, "_mp"}, bif.stat_mispred_o, exp_mp);
  endtask

  task automatic check_pred(input string tag, input logic [31:0] pc, input logic exp);
    bif.if_pc_i = pc;
    #1;
    check(tag, {31'd0, bif.if_pred_taken_o}, {31'd0, exp});
  endtask

  initial begin
    n_checks = 0; n_errors = 0; exp_br = 0; exp_mp = 0;
    rst_n = 1'b0;
    idle();
    bif.ex_funct3_i = 3'b000; bif.ex_pc_i = 32'd0; bif.ex_target_i = 32'd0;
    bif.BrEq_i = 1'b0; bif.BrLt_i = 1'b0; bif.if_pc_i = 32'd0;

    // Reset for two cycles
    step(); step();
    check("rst_pcsel", {31'd0, bif.PCSel_o}, 32'd0);
    check("rst_flush", {31'd0, bif.flush_o}, 32'd0);
    check("rst_illegal", {31'd0, bif.illegal_br_o}, 32'd0);
    check("rst_redir", bif.redirect_pc_o, 32'd0);
    check_stats("rst");
    check_pred("rst_pred100", 32'h100, 1'b0);
    check_pred("rst_pred104", 32'h104, 1'b0);
    rst_n = 1'b1;
    step();

    // BEQ taken mispredicted at 0x100
    drive(3'b000, 32'h100, 32'h140, 1'b0, 1'b1, 1'b0);
    check_pred("beq_pred_pre", 32'h100, 1'b0);
    step(); idle();
    exp_br++; exp_mp++;
    check("beq_pcsel", {31'd0, bif.PCSel_o}, 32'd1);
    check("beq_flush", {31'd0, bif.flush_o}, 32'd1);
    check("beq_redir", bif.redirect_pc_o, 32'h140);
    check_stats("beq");
    check_pred("beq_pred_post", 32'h100, 1'b1);
    step();
    check("beq_pcsel_off", {31'd0, bif.PCSel_o}, 32'd0);
    check("beq_redir_hold", bif.redirect_pc_o, 32'h140);

    // BLTU: A=0xFFFFFFFF, B=1 unsigned -> BrLt=0, not-taken, correct
    drive(3'b110, 32'h208, 32'h300, 1'b0, 1'b0, 1'b0);
    #1; check("bltu_brun", {31'd0, bif.BrUn_o}, 32'd1);
    step(); idle(); exp_br++;
    check("bltu_pcsel", {31'd0, bif.PCSel_o}, 32'd0);
    check_stats("bltu");
    // BLT: same operands signed -> BrLt=1, taken, mispredicted
    drive(3'b100, 32'h20C, 32'h300, 1'b0, 1'b0, 1'b1);
    #1; check("blt_brun", {31'd0, bif.BrUn_o}, 32'd0);
    step(); idle(); exp_br++; exp_mp++;
    check("blt_pcsel", {31'd0, bif.PCSel_o}, 32'd1);
    check("blt_redir", bif.redirect_pc_o, 32'h300);
    check_stats("blt");
    step();

    // Saturation at 0x104 (entry 1 starts at 01)
    drive(3'b001, 32'h104, 32'h180, 1'b0, 1'b0, 1'b0);
    step(); idle(); exp_br++; exp_mp++;
    check("sat1_pcsel", {31'd0, bif.PCSel_o}, 32'd1);
    check("sat1_redir", bif.redirect_pc_o, 32'h180);
    step();
    for (int k = 2; k <= 4; k++) begin
      drive(3'b001, 32'h104, 32'h180, 1'b1, 1'b0, 1'b0);
      step(); idle(); exp_br++;
      check($sformatf("sat%0d_pcsel", k), {31'd0, bif.PCSel_o}, 32'd0);
      check_pred($sformatf("sat%0d_pred", k), 32'h104, 1'b1);
    end
    check_stats("sat");
    drive(3'b001, 32'h104, 32'h180, 1'b1, 1'b1, 1'b0);
    step(); idle(); exp_br++; exp_mp++;
    check("satnt1_pcsel", {31'd0, bif.PCSel_o}, 32'd1);
    check("satnt1_redir", bif.redirect_pc_o, 32'h108);
    check_pred("satnt1_pred", 32'h104, 1'b1);
    step();
    drive(3'b001, 32'h104, 32'h180, 1'b1, 1'b1, 1'b0);
    step(); idle(); exp_br++; exp_mp++;
    check_pred("satnt2_pred", 32'h104, 1'b0);
    check_stats("satnt");
    step();

    // Flush shadow
    drive(3'b000, 32'h110, 32'h400, 1'b0, 1'b1, 1'b0);
    step(); exp_br++; exp_mp++;
    drive(3'b000, 32'h114, 32'h500, 1'b0, 1'b1, 1'b0);
    check("sh_pcsel", {31'd0, bif.PCSel_o}, 32'd1);
    step(); idle();
    check("sh_pcsel2", {31'd0, bif.PCSel_o}, 32'd0);
    check("sh_redir", bif.redirect_pc_o, 32'h400);
    check_stats("sh");
    check_pred("sh_pred114", 32'h114, 1'b0);

    // Stall for three cycles, then release
    drive(3'b000, 32'h118, 32'h600, 1'b0, 1'b1, 1'b0);
    bif.stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("st%0d_pcsel", k), {31'd0, bif.PCSel_o}, 32'd0);
      check_stats($sformatf("st%0d", k));
    end
    check_pred("st_pred_pre", 32'h118, 1'b0);
    bif.stall_i = 1'b0;
    step(); exp_br++; exp_mp++;
    // Pending redirect completes despite a stall in its own cycle
    bif.stall_i = 1'b1;
    check("st_pcsel", {31'd0, bif.PCSel_o}, 32'd1);
    check("st_redir", bif.redirect_pc_o, 32'h600);
    check_stats("st");
    check_pred("st_pred_post", 32'h118, 1'b1);
    step(); idle(); step();
    check_stats("st_after");

    // Illegal funct3 010
    drive(3'b010, 32'h11C, 32'h700, 1'b0, 1'b1, 1'b0);
    step(); idle();
    check("ill_pulse", {31'd0, bif.illegal_br_o}, 32'd1);
    check("ill_pcsel", {31'd0, bif.PCSel_o}, 32'd0);
    check_stats("ill");
    step();
    check("ill_pulse_off", {31'd0, bif.illegal_br_o}, 32'd0);

    // Reset in the cycle a mispredict resolves
    drive(3'b000, 32'h120, 32'h800, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    step(); idle(); exp_br = 0; exp_mp = 0;
    check("rr_pcsel", {31'd0, bif.PCSel_o}, 32'd0);
    check("rr_redir", bif.redirect_pc_o, 32'd0);
    check_stats("rr");
    check_pred("rr_pred104", 32'h104, 1'b0);
    check_pred("rr_pred118", 32'h118, 1'b0);
    rst_n = 1'b1;
    step();
    check("rr_pcsel2", {31'd0, bif.PCSel_o}, 32'd0);
    check("rr_flush2", {31'd0, bif.flush_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Branch resolution and prediction controller for the EX stage of the 5-stage RISC-V pipeline.
- Drives BrUn to the branch comparator from the B-type funct3.
- Combines BrEq/BrLt into the actual outcome and checks it against the IF-stage prediction.
- Issues a registered redirect/flush on mispredict and maintains a table of 2-bit saturating branch-history counters that supplies fetch-time predictions.

Parameters:
IDX_W, 4, BHT index width; table holds 2^IDX_W counters indexed by pc[IDX_W+1:2]
CNT_INIT, 2'b01, counter reset value (weakly not-taken)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_ni  in  1  synchronous active-low reset
stall_i  in  1  EX stage held this cycle
ex_valid_i  in  1  EX holds a valid instruction
ex_is_branch_i  in  1  EX instruction is conditional branch (B-type)
ex_funct3_i  in  3  branch funct3
ex_pc_i  in  32  PC of EX instruction
ex_target_i  in  32  computed branch target (pc+imm)
ex_pred_taken_i  in  1  prediction carried from IF with this instruction
BrUn_o  out  1  to comparator: 1 = unsigned compare
BrEq_i  in  1  from comparator
BrLt_i  in  1  from comparator
if_pc_i  in  32  current fetch PC
if_pred_taken_o  out  1  BHT prediction for if_pc_i
PCSel_o  out  1  redirect PC this cycle (registered)
redirect_pc_o  out  32  redirect address (registered)
flush_o  out  1  kill IF/ID/EX younger instructions (registered, equals PCSel_o)
illegal_br_o  out  1  registered pulse: branch with funct3 010/011
stat_branches_o  out  32  resolved-branch count
stat_mispred_o  out  32  mispredict count

Behaviour:
- BrUn_o = ex_funct3_i[1]. Combinational, always driven, independent of valid.
- Resolve condition: res = ex_valid_i & ex_is_branch_i & !stall_i & !flush_o.
  - Instructions in EX during a flush_o cycle are wrong-path and are ignored.
- Actual outcome by funct3, computed combinationally:
  - 000 BEQ: BrEq_i.
  - 001 BNE: !BrEq_i.
  - 100 BLT and 110 BLTU: BrLt_i.
  - 101 BGE and 111 BGEU: !BrLt_i.
  - 010/011: illegal. Outcome is not-taken, illegal_br_o pulses next cycle, BHT is not updated, stat counters are not incremented.
- Mispredict: res & legal & (taken != ex_pred_taken_i).
  - Next cycle: PCSel_o=1 and flush_o=1 for exactly one cycle.
  - redirect_pc_o = ex_target_i if taken, else ex_pc_i+4 (32-bit wrap).
  - Latency: one cycle from resolution to redirect.
  - Redirect is not suppressed by stall_i in its own cycle; the PC unit must accept it.
- redirect_pc_o holds its last value when PCSel_o=0.
- BHT update on res & legal, at the same clock edge as the redirect register:
  - taken: counter +1, saturating at 11.
  - not-taken: counter -1, saturating at 00.
  - Index is ex_pc_i[IDX_W+1:2].
- if_pred_taken_o = bht[if_pc_i[IDX_W+1:2]][1], combinational read.
  - Same-cycle write to the same index: the read returns the pre-update value (no bypass).
- Stat counters, both 32-bit and wrapping:
  - stat_branches_o increments on res & legal.
  - stat_mispred_o increments on mispredict.
- stall_i=1: no resolution, no BHT/stat change; a pending registered redirect still completes.
- Back-to-back: a branch resolving in the cycle immediately after a mispredict is in the flush shadow and is ignored.
- Reset (rst_ni=0 at a clock edge), including mid-operation:
  - PCSel_o=0, flush_o=0, illegal_br_o=0, redirect_pc_o=0.
  - Stat counters=0, all BHT entries=CNT_INIT.
  - A pending redirect is dropped.

Test Plan:
- Reset with rst_ni=0 for 2 cycles.
  -> All outputs 0, if_pred_taken_o=0 for any PC, stats 0.
- BEQ at pc 0x100, target 0x140, BrEq=1, pred=0.
  -> Next cycle PCSel_o=flush_o=1, redirect_pc_o=0x140, stat_mispred_o=1.
  -> bht[0]=10, so if_pred_taken_o=1 for if_pc 0x100.
- BLTU vs BLT with funct3 110/100.
  -> BrUn_o=1/0 respectively.
  -> Comparator with A=0xFFFFFFFF, B=1 gives BrLt=0 for BLTU (not-taken) and BrLt=1 for BLT (taken).
- Saturation: 4 taken BNEs at pc 0x104.
  -> Counter goes 01→10→11→11.
  -> Then one not-taken gives 10 and if_pred_taken_o stays 1.
  -> Predicted-correct resolutions give PCSel_o=0.
- Flush shadow: mispredict at cycle N, then a valid mispredicting branch in EX at cycle N+1.
  -> No second redirect at N+2, no BHT/stat change.
- stall_i=1 with a valid branch for 3 cycles, then released.
  -> Exactly one resolution and one stat increment.
- funct3=010 valid branch.
  -> illegal_br_o pulse, no redirect when pred=0, stats unchanged.
- Reset asserted in the cycle a mispredict resolves.
  -> No PCSel_o pulse afterward.
